// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the RVX10-P pipeline control: forwarding selects, FSM states, result codes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } ctrl_state_e;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // MEM stage wins over WB because it holds the younger write to the same register.
  function automatic fwd_sel_e fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                       input logic [4:0] rd_w, input logic we_m,
                                       input logic we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))      return FWD_MEM;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    else                                             return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; increments one cycle after inc, holds at all-ones, no backpressure.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline: forwarding, stall/flush, dmem wait with timeout.
// Stall/flush/forward are same-cycle combinational; mem_err and counters update on the next edge.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  ctrl_state_e    state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_err_q, mem_err_d;

  logic lw_stall;
  logic timeout_hit;
  logic mem_stall;
  logic flush_inc;

  assign ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

  assign lw_stall    = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
  assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == WCW'(TIMEOUT));
  assign mem_stall   = MemReqM && !dmem_ready && !timeout_hit;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      default: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (timeout_hit) begin
          // Release the pipeline with undefined load data and flag it.
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else if (!MemReqM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // A frozen EX stage hides lwStall/PCSrcE until the memory access releases.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign flush_inc = reset && !mem_stall && PCSrcE;
  assign mem_err   = mem_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .q     (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .q     (flush_events)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT=4 and 4-bit counters so saturation is reachable.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int n_checks = 0;
  int n_fail   = 0;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  logic [6:0] ctl;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  localparam logic [6:0] CTL_NONE  = 7'b0000000;
  localparam logic [6:0] CTL_RST   = 7'b0000111;
  localparam logic [6:0] CTL_LW    = 7'b1100010;
  localparam logic [6:0] CTL_BR    = 7'b0000110;
  localparam logic [6:0] CTL_MEM   = 7'b1111001;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .ResultSrcE   (ResultSrcE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .PCSrcE       (PCSrcE),
    .MemReqM      (MemReqM),
    .dmem_ready   (dmem_ready),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
    RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    clear_inputs();
    #3;
    chk("rst_ctl", 32'(ctl), 32'(CTL_RST));
    chk("rst_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_flush_cnt", 32'(flush_events), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);

    @(negedge clk); reset = 1'b1; #1;
    chk("idle_ctl", 32'(ctl), 32'(CTL_NONE));

    // Forwarding priority
    RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
    chk("fwdA_mem", 32'(ForwardAE), 32'd2);
    chk("fwdB_mem", 32'(ForwardBE), 32'd2);
    RdM = 5'd0; #1;
    chk("fwdA_wb", 32'(ForwardAE), 32'd1);
    RdM = 5'd5; RegWriteM = 1'b0; Rs2E = 5'd9; #1;
    chk("fwdA_wb_nowe", 32'(ForwardAE), 32'd1);
    chk("fwdB_none", 32'(ForwardBE), 32'd0);
    RegWriteM = 1'b1; Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0; #1;
    chk("fwdA_rf", 32'(ForwardAE), 32'd0);
    chk("fwd_ctl_quiet", 32'(ctl), 32'(CTL_NONE));
    clear_inputs();

    // Load-use hazard and non-hazards
    @(negedge clk); set_load_use(); #1;
    chk("lw_ctl", 32'(ctl), 32'(CTL_LW));
    chk("lw_cnt_before", 32'(stall_cycles), 32'd0);
    @(negedge clk); clear_inputs(); #1;
    chk("lw_cnt_after", 32'(stall_cycles), 32'd1);
    chk("lw_released", 32'(ctl), 32'(CTL_NONE));
    ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0; #1;
    chk("lw_x0_nostall", 32'(ctl), 32'(CTL_NONE));
    ResultSrcE = 2'b10; RdE = 5'd3; Rs1D = 5'd3; #1;
    chk("alu_nostall", 32'(ctl), 32'(CTL_NONE));
    clear_inputs();

    // Branch overrides load-use
    @(negedge clk); set_load_use(); PCSrcE = 1'b1; #1;
    chk("br_ctl", 32'(ctl), 32'(CTL_BR));
    @(negedge clk); clear_inputs(); #1;
    chk("br_flush_cnt", 32'(flush_events), 32'd1);
    chk("br_stall_cnt", 32'(stall_cycles), 32'd1);

    // Memory wait: three not-ready cycles, ready on the fourth
    @(negedge clk); MemReqM = 1'b1; dmem_ready = 1'b0; #1;
    chk("mw_c1", 32'(ctl), 32'(CTL_MEM));
    @(negedge clk); set_load_use(); PCSrcE = 1'b1; #1;
    chk("mw_c2_masks_br", 32'(ctl), 32'(CTL_MEM));
    @(negedge clk); ResultSrcE = 2'b00; RdE = 5'd0; Rs2D = 5'd0; PCSrcE = 1'b0; #1;
    chk("mw_c3", 32'(ctl), 32'(CTL_MEM));
    @(negedge clk); dmem_ready = 1'b1; #1;
    chk("mw_release", 32'(ctl), 32'(CTL_NONE));
    @(negedge clk); clear_inputs(); #1;
    chk("mw_stall_cnt", 32'(stall_cycles), 32'd4);
    chk("mw_flush_cnt", 32'(flush_events), 32'd1);
    chk("mw_no_err", 32'(mem_err), 32'd0);

    // Timeout: four stalled cycles, then forced release
    @(negedge clk); MemReqM = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      chk($sformatf("to_stall_%0d", i), 32'(ctl), 32'(CTL_MEM));
      @(negedge clk);
    end
    #1;
    chk("to_release", 32'(ctl), 32'(CTL_NONE));
    chk("to_err_not_yet", 32'(mem_err), 32'd0);
    @(negedge clk); MemReqM = 1'b0; #1;
    chk("to_err_set", 32'(mem_err), 32'd1);
    chk("to_stall_cnt", 32'(stall_cycles), 32'd8);
    @(negedge clk); #1;
    chk("to_err_sticky", 32'(mem_err), 32'd1);

    // Saturation: 8 + 7 reaches 15, further stalls hold it
    set_load_use();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      if (i == 7)  chk("sat_reach", 32'(stall_cycles), 32'd15);
      if (i == 10) chk("sat_hold", 32'(stall_cycles), 32'd15);
    end
    clear_inputs();

    // Asynchronous reset in the middle of a wait
    @(negedge clk); MemReqM = 1'b1; dmem_ready = 1'b0;
    @(negedge clk); #1;
    chk("ar_waiting", 32'(ctl), 32'(CTL_MEM));
    #1; reset = 1'b0; #1;
    chk("ar_ctl", 32'(ctl), 32'(CTL_RST));
    chk("ar_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("ar_flush_cnt", 32'(flush_events), 32'd0);
    chk("ar_mem_err", 32'(mem_err), 32'd0);
    @(negedge clk); MemReqM = 1'b0; reset = 1'b1; #1;
    chk("ar_after_ctl", 32'(ctl), 32'(CTL_NONE));
    @(negedge clk); MemReqM = 1'b1; #1;
    chk("ar_fresh_stall", 32'(ctl), 32'(CTL_MEM));
    @(negedge clk); dmem_ready = 1'b1; #1;
    chk("ar_fresh_release", 32'(ctl), 32'(CTL_NONE));
    chk("ar_fresh_cnt", 32'(stall_cycles), 32'd1);
    clear_inputs();

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
